// File: rtl/ssd_pkg.sv
// Shared encodings for the ssd_sim host controller: command ops, response
// status codes and controller states.
package ssd_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_RANGE_ERR = 2'b01,
    ST_TIMEOUT   = 2'b10,
    ST_BAD_OP    = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/ssd_wdog.sv
// Saturating watchdog counter with clear/enable; expired is raised on the
// cycle whose increment reaches TIMEOUT_CYCLES, and stays high once saturated.
module ssd_wdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Look-ahead so the abort lands on the Nth waiting cycle, not one later.
  assign expired = (count_q == LIMIT) || (en && (count_q == LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ssd_host_ctrl.sv
// Host-side initiator for ssd_sim: accepts one command at a time, strobes the
// SSD, waits for done under a watchdog and returns a registered response.
module ssd_host_ctrl
  import ssd_pkg::*;
#(
  parameter int VALUE_SIZE     = 32,
  parameter int DATA_SIZE      = 512,
  parameter int SSD_CAPACITY   = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [VALUE_SIZE-1:0] cmd_addr,
  input  logic [DATA_SIZE-1:0]  cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_op,
  output logic [1:0]            rsp_status,
  output logic [VALUE_SIZE-1:0] rsp_addr,
  output logic [DATA_SIZE-1:0]  rsp_data,
  output logic                  ssd_write,
  output logic                  ssd_read,
  output logic                  ssd_delete,
  output logic [DATA_SIZE-1:0]  ssd_data_in,
  output logic [VALUE_SIZE-1:0] ssd_addr_in,
  input  logic [VALUE_SIZE-1:0] ssd_addr_out,
  input  logic [DATA_SIZE-1:0]  ssd_data_out,
  input  logic                  ssd_ready,
  input  logic                  ssd_done
);

  localparam logic [VALUE_SIZE-1:0] CAP = VALUE_SIZE'(SSD_CAPACITY);

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [1:0]            op_q, op_d;
  logic [VALUE_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]  data_q, data_d;
  logic                  wr_q, wr_d, rd_q, rd_d, del_q, del_d;
  logic [VALUE_SIZE-1:0] ssd_addr_in_q, ssd_addr_in_d;
  logic [DATA_SIZE-1:0]  ssd_data_in_q, ssd_data_in_d;
  logic [1:0]            rsp_op_q, rsp_op_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [VALUE_SIZE-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_SIZE-1:0]  rsp_data_q, rsp_data_d;
  logic                  wdog_clr, wdog_en, wdog_expired;

  ssd_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wdog_clr),
    .en     (wdog_en),
    .expired(wdog_expired)
  );

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wr_d          = 1'b0;
    rd_d          = 1'b0;
    del_d         = 1'b0;
    ssd_addr_in_d = ssd_addr_in_q;
    ssd_data_in_d = ssd_data_in_q;
    rsp_op_d      = rsp_op_q;
    rsp_status_d  = rsp_status_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_data_d    = rsp_data_q;
    wdog_clr      = 1'b0;
    wdog_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          addr_d      = cmd_addr;
          data_d      = cmd_data;
          cmd_ready_d = 1'b0;
          rsp_op_d    = cmd_op;
          rsp_addr_d  = cmd_addr;
          rsp_data_d  = '0;
          if (cmd_op == OP_NOP) begin
            rsp_status_d = ST_BAD_OP;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end else if (cmd_addr >= CAP) begin
            rsp_status_d = ST_RANGE_ERR;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // A done still high from the previous op must clear before we strobe.
        if (ssd_ready && !ssd_done) begin
          ssd_addr_in_d = addr_q;
          ssd_data_in_d = (op_q == OP_WRITE) ? data_q : '0;
          wr_d          = (op_q == OP_WRITE);
          rd_d          = (op_q == OP_READ);
          del_d         = (op_q == OP_DELETE);
          wdog_clr      = 1'b1;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (ssd_done) begin
          rsp_status_d = ST_OK;
          rsp_addr_d   = (op_q == OP_WRITE) ? ssd_addr_out : addr_q;
          rsp_data_d   = (op_q == OP_READ) ? ssd_data_out : '0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          wdog_en = 1'b1;
          if (wdog_expired) begin
            rsp_status_d = ST_TIMEOUT;
            rsp_addr_d   = addr_q;
            rsp_data_d   = '0;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      op_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      del_q         <= 1'b0;
      ssd_addr_in_q <= '0;
      ssd_data_in_q <= '0;
      rsp_op_q      <= '0;
      rsp_status_q  <= '0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      del_q         <= del_d;
      ssd_addr_in_q <= ssd_addr_in_d;
      ssd_data_in_q <= ssd_data_in_d;
      rsp_op_q      <= rsp_op_d;
      rsp_status_q  <= rsp_status_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_data    = rsp_data_q;
  assign ssd_write   = wr_q;
  assign ssd_read    = rd_q;
  assign ssd_delete  = del_q;
  assign ssd_addr_in = ssd_addr_in_q;
  assign ssd_data_in = ssd_data_in_q;

endmodule

// File: tb/tb_ssd_host_ctrl.sv
// Self-checking bench for ssd_host_ctrl: a behavioural SSD responder plus a
// reference model of expected responses, driven by directed and random commands.
module tb_ssd_host_ctrl;
  import ssd_pkg::*;

  localparam int VS = 32;
  localparam int DS = 512;
  localparam int CAP = 32;
  localparam int TO = 64;
  localparam logic [VS-1:0] ADDR_OFS = 32'h100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [VS-1:0] cmd_addr = '0;
  logic [DS-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_op, rsp_status;
  logic [VS-1:0] rsp_addr;
  logic [DS-1:0] rsp_data;
  logic          ssd_write, ssd_read, ssd_delete;
  logic [DS-1:0] ssd_data_in;
  logic [VS-1:0] ssd_addr_in;
  logic [VS-1:0] ssd_addr_out = '0;
  logic [DS-1:0] ssd_data_out = '0;
  logic          ssd_ready = 1'b1;
  logic          ssd_done = 1'b0;

  always #5 clk = ~clk;

  ssd_host_ctrl #(
    .VALUE_SIZE(VS), .DATA_SIZE(DS), .SSD_CAPACITY(CAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_status(rsp_status), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .ssd_write(ssd_write), .ssd_read(ssd_read), .ssd_delete(ssd_delete),
    .ssd_data_in(ssd_data_in), .ssd_addr_in(ssd_addr_in),
    .ssd_addr_out(ssd_addr_out), .ssd_data_out(ssd_data_out),
    .ssd_ready(ssd_ready), .ssd_done(ssd_done)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [DS-1:0] rand_data();
    logic [DS-1:0] d;
    for (int i = 0; i < DS / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Behavioural SSD: counts strobes, stores data, reports done after done_delay.
  logic [DS-1:0] ssd_mem [CAP];
  logic [VS-1:0] last_addr = '0;
  logic [DS-1:0] last_data = '0;
  int n_wr = 0, n_rd = 0, n_del = 0, pend = -1, done_delay = 0;
  bit done_never = 1'b0, force_done = 1'b0;

  always @(negedge clk) begin
    ssd_done = force_done;
    if (reset) begin
      pend = -1;
      for (int i = 0; i < CAP; i++) ssd_mem[i] = '0;
    end else if (ssd_write || ssd_read || ssd_delete) begin
      if (ssd_write) begin n_wr++; ssd_mem[ssd_addr_in[4:0]] = ssd_data_in; end
      if (ssd_read) n_rd++;
      if (ssd_delete) begin n_del++; ssd_mem[ssd_addr_in[4:0]] = '0; end
      ssd_data_out = ssd_read ? ssd_mem[ssd_addr_in[4:0]] : rand_data();
      ssd_addr_out = ssd_addr_in + ADDR_OFS;
      last_addr = ssd_addr_in;
      last_data = ssd_data_in;
      pend = done_delay;
    end else if (pend > 0) begin
      pend--;
    end
    if (pend == 0 && !done_never) begin
      ssd_done = 1'b1;
      pend = -1;
    end
  end

  // Reference model: the response each command should produce, from op rules alone.
  logic [DS-1:0] ref_mem [CAP];

  function automatic void ref_rsp(input logic [1:0] op, input logic [VS-1:0] addr,
                                  input logic [DS-1:0] data, input bit timed_out,
                                  output logic [1:0] st, output logic [VS-1:0] ra,
                                  output logic [DS-1:0] rd, output bit strobe);
    ra = addr;
    rd = '0;
    strobe = 1'b0;
    if (op == OP_NOP) begin
      st = ST_BAD_OP;
    end else if (addr >= VS'(CAP)) begin
      st = ST_RANGE_ERR;
    end else if (timed_out) begin
      st = ST_TIMEOUT;
      strobe = 1'b1;
    end else begin
      st = ST_OK;
      strobe = 1'b1;
      case (op)
        OP_WRITE: begin ref_mem[addr[4:0]] = data; ra = addr + ADDR_OFS; end
        OP_READ:  rd = ref_mem[addr[4:0]];
        default:  ref_mem[addr[4:0]] = '0;
      endcase
    end
  endfunction

  // Full transaction: submit, await response (holding rsp_ready low 'hold' cycles), check.
  task automatic do_txn(input logic [1:0] op, input logic [VS-1:0] addr,
                        input logic [DS-1:0] data, input bit timed_out,
                        input int hold, output int lat);
    logic [1:0] est, s_op, s_st;
    logic [VS-1:0] ea, s_a;
    logic [DS-1:0] ed, s_d;
    bit es;
    int w0, r0, d0, n, ew, er, edl;
    ref_rsp(op, addr, data, timed_out, est, ea, ed, es);
    w0 = n_wr; r0 = n_rd; d0 = n_del;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = rand_data();
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 1000);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_wait: rsp_valid=%b required 1", rsp_valid);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL busy_ready: cmd_ready=%b required 0", cmd_ready);
    end
    checks++;
    if (rsp_op !== op) begin
      errors++; $display("FAIL rsp_op: got %0d required %0d", rsp_op, op);
    end
    checks++;
    if (rsp_status !== est) begin
      errors++; $display("FAIL rsp_status: got %0d required %0d", rsp_status, est);
    end
    checks++;
    if (rsp_addr !== ea) begin
      errors++; $display("FAIL rsp_addr: got %h required %h", rsp_addr, ea);
    end
    checks++;
    if (rsp_data !== ed) begin
      errors++; $display("FAIL rsp_data: got %h required %h", rsp_data[63:0], ed[63:0]);
    end
    s_op = rsp_op; s_st = rsp_status; s_a = rsp_addr; s_d = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, rsp_op, rsp_status, rsp_addr, rsp_data} !==
          {1'b1, 1'b0, s_op, s_st, s_a, s_d}) begin
        errors++;
        $display("FAIL rsp_hold: cycle %0d valid=%b ready=%b status=%0d required stable", h,
                 rsp_valid, cmd_ready, rsp_status);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ew = (es && op == OP_WRITE) ? 1 : 0;
    er = (es && op == OP_READ) ? 1 : 0;
    edl = (es && op == OP_DELETE) ? 1 : 0;
    checks++;
    if ((n_wr - w0) != ew || (n_rd - r0) != er || (n_del - d0) != edl) begin
      errors++;
      $display("FAIL strobes: wr/rd/del=%0d/%0d/%0d required %0d/%0d/%0d",
               n_wr - w0, n_rd - r0, n_del - d0, ew, er, edl);
    end
    if (es) begin
      checks++;
      if (last_addr !== addr || last_data !== ((op == OP_WRITE) ? data : '0)) begin
        errors++;
        $display("FAIL ssd_bus: addr_in=%h data_in=%h required addr %h", last_addr,
                 last_data[63:0], addr);
      end
    end
    $display("txn op=%0d addr=%h status=%0d latency=%0d", op, addr, rsp_status, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++;
    if ({ssd_write, ssd_read, ssd_delete} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b required 000", {ssd_write, ssd_read, ssd_delete});
    end
    checks++;
    if (ssd_addr_in !== '0 || ssd_data_in !== '0) begin
      errors++; $display("FAIL reset_ssd_bus: addr=%h required 0", ssd_addr_in);
    end
    checks++;
    if ({rsp_op, rsp_status, rsp_addr, rsp_data} !== '0) begin
      errors++; $display("FAIL reset_rsp_fields: status=%0d addr=%h required 0", rsp_status, rsp_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat;
    done_delay = 0;
    do_txn(OP_WRITE, 32'h0, {64{8'hA0}}, 1'b0, 0, lat);
    // Accept edge, issue edge, done sampled on the following edge.
    checks++;
    if (lat != 3) begin errors++; $display("FAIL min_latency: got %0d required 3", lat); end
    do_txn(OP_READ, 32'h0, '0, 1'b0, 0, lat);
    do_txn(OP_DELETE, 32'h0, '0, 1'b0, 0, lat);
    do_txn(OP_READ, 32'h0, '0, 1'b0, 0, lat);
  endtask

  task automatic test_range();
    int lat;
    do_txn(OP_WRITE, 32'h1024, rand_data(), 1'b0, 0, lat);
    do_txn(OP_READ, 32'd32, '0, 1'b0, 0, lat);
    do_txn(OP_WRITE, 32'h1F, rand_data(), 1'b0, 0, lat);
    do_txn(OP_NOP, 32'h2, rand_data(), 1'b0, 0, lat);
  endtask

  task automatic test_timeout();
    int lat;
    done_never = 1'b1;
    do_txn(OP_READ, 32'h3, '0, 1'b1, 0, lat);
    done_never = 1'b0;
    // Strobe-to-response distance is TO cycles, plus accept and issue.
    checks++;
    if (lat != TO + 2) begin errors++; $display("FAIL timeout_cycles: got %0d required %0d", lat, TO + 2); end
    do_txn(OP_READ, 32'h1F, '0, 1'b0, 0, lat);
  endtask

  task automatic test_issue_hold();
    int lat, w0, r0;
    done_delay = 1;
    ssd_ready = 1'b0;
    w0 = n_wr;
    fork
      begin
        repeat (6) @(negedge clk);
        checks++;
        if (n_wr != w0) begin errors++; $display("FAIL ready_hold: strobes=%0d required 0", n_wr - w0); end
        ssd_ready = 1'b1;
      end
      do_txn(OP_WRITE, 32'h7, rand_data(), 1'b0, 0, lat);
    join
    force_done = 1'b1;
    r0 = n_rd;
    fork
      begin
        repeat (6) @(negedge clk);
        checks++;
        if (n_rd != r0) begin errors++; $display("FAIL stale_done: strobes=%0d required 0", n_rd - r0); end
        force_done = 1'b0;
      end
      do_txn(OP_READ, 32'h7, '0, 1'b0, 3, lat);
    join
    done_delay = 0;
  endtask

  task automatic test_random();
    int lat;
    logic [1:0] op;
    logic [VS-1:0] addr;
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 7) == 0) ? VS'(CAP + $urandom_range(0, 500))
                                         : VS'($urandom_range(0, CAP - 1));
      done_delay = $urandom_range(0, 3);
      do_txn(op, addr, rand_data(), 1'b0, $urandom_range(0, 1), lat);
    end
    done_delay = 0;
  endtask

  task automatic test_back_to_back();
    int lat, w0, seen;
    for (int i = 0; i < 32; i++) begin
      do_txn(OP_WRITE, VS'(i), DS'({8{32'(i)}}), 1'b0, 0, lat);
    end
    done_never = 1'b1;
    w0 = n_wr;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 32'h5; cmd_data = rand_data();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (n_wr - w0 != 1) begin errors++; $display("FAIL abort_issue: strobes=%0d required 1", n_wr - w0); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, ssd_write, ssd_read, ssd_delete, ssd_addr_in, rsp_status, rsp_addr} !==
        {1'b1, 1'b0, 3'b000, VS'(0), 2'b00, VS'(0)}) begin
      errors++;
      $display("FAIL abort_reset: ready=%b valid=%b addr_in=%h required reset values",
               cmd_ready, rsp_valid, ssd_addr_in);
    end
    seen = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_rsp: valid cycles=%0d required 0", seen); end
    done_never = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < CAP; i++) ref_mem[i] = '0;
    test_reset();
    test_write_read();
    test_range();
    test_timeout();
    test_issue_hold();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
